riscv_wb_sched: RTL
===================

RISCV_WB_SCHED -- requirements
Module: riscv_wb_sched

Interface
REQ-001 SHALL have parameter XLEN, default 32, register data width.
REQ-002 SHALL have parameter DEPTH, default 2, entries in the deferred-ALU-write queue.
REQ-003 SHALL have port clk  input  1  the only clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port ex_valid  input  1  ALU result present this cycle.
REQ-006 SHALL have port ex_rd  input  5  ALU destination register.
REQ-007 SHALL have port ex_data  input  XLEN  ALU result.
REQ-008 SHALL have port mem_valid  input  1  load return present this cycle.
REQ-009 SHALL have port mem_rd  input  5  load destination register.
REQ-010 SHALL have port mem_data  input  XLEN  load data.
REQ-011 SHALL have port q_rs  input  5  forwarding query register index.
REQ-012 SHALL have port wr_en  output  1  register-file write strobe.
REQ-013 SHALL have port wr_rd  output  5  register-file write index.
REQ-014 SHALL have port wr_data  output  XLEN  register-file write data.
REQ-015 SHALL have port bubble  output  1  stall request to upstream/PC; queue full.
REQ-016 SHALL have port q_hit  output  1  q_rs matches a queued entry.
REQ-017 SHALL have port q_data  output  XLEN  data of youngest matching queued entry.
REQ-018 SHALL have port wr_on_zero  output  1  one-cycle pulse: a write to x0 was discarded.
REQ-019 SHALL have port overflow  output  1  sticky: ex write arrived while bubble was high.

Function
REQ-020 SHALL share the single register-file write port among three sources, priority: mem > queue head > new ex.
REQ-021 SHALL register the winner: wr_en/wr_rd/wr_data valid the cycle after selection (latency 1).
REQ-022 SHALL push ex into queue tail when ex_valid and it loses (mem_valid or queue non-empty).
REQ-023 SHALL pop queue head when it wins; push and pop in the same cycle leave count unchanged.
REQ-024 SHALL preserve ALU write order: new ex never bypasses a queued entry.
REQ-025 SHALL treat mem writes as older than any queued or concurrent ex write (no WAW check needed).
REQ-026 SHALL track occupancy as states EMPTY (0), PART (1..DEPTH-1), FULL (DEPTH); transitions by push/pop only.
REQ-027 SHALL drive bubble combinationally = (state == FULL).
REQ-028 SHALL drop ex when ex_valid and bubble and no pop this cycle, and set overflow until reset.
REQ-029 SHALL drop any selected write with rd == 0: wr_en stays 0, wr_on_zero pulses 1 next cycle.
REQ-030 SHALL drive q_hit/q_data combinationally from queue contents; multiple matches -> youngest entry; q_rs == 0 -> q_hit 0.
REQ-031 SHALL hold wr_rd/wr_data stable when wr_en is 0 (no toggling on idle cycles).
REQ-032 SHALL wrap head/tail pointers modulo DEPTH.

Reset
REQ-033 SHALL on rst low immediately clear wr_en, wr_rd, wr_data, wr_on_zero, overflow to 0 and set state EMPTY.
REQ-034 SHALL discard all queued writes on reset mid-operation; no write issued for them afterwards.
REQ-035 SHALL resume arbitration on the first rising clk after rst deasserts.

Structure
REQ-036 SHALL take XLEN, REGN (32) and DEPTH defaults from shared package riscv_pkg.
REQ-037 SHALL implement the queue as sub-module riscv_wb_fifo (push/pop/count/entry read-out for lookup).

Verification
REQ-038 SHALL cover: ex only, rd=5 data 0xA -> next cycle wr_en=1, wr_rd=5, wr_data=0xA.
REQ-039 SHALL cover: mem rd=3 0x11 with ex rd=4 0x22 same cycle -> cycle+1 writes x3=0x11, cycle+2 writes x4=0x22, q_hit for q_rs=4 during cycle+1.
REQ-040 SHALL cover: mem_valid held 3 cycles plus ex each cycle -> bubble rises after 2 pushes; third ex dropped, overflow=1.
REQ-041 SHALL cover: ex rd=0 -> wr_en=0, wr_on_zero=1 for one cycle.
REQ-042 SHALL cover: two queued writes to x7 (0x1 then 0x2), q_rs=7 -> q_data=0x2; drained in order 0x1, 0x2.
REQ-043 SHALL cover: rst low with queue FULL -> bubble=0, outputs 0 immediately; no queued write ever appears.

Source files
------------

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared core widths, register count and writeback queue depth.
// Also holds the occupancy state type and the x0 test used by the scheduler.
package riscv_pkg;

    localparam int XLEN_D  = 32;
    localparam int REGN    = 32;
    localparam int RW      = $clog2(REGN);
    localparam int DEPTH_D = 2;

    typedef enum logic [1:0] {
        OCC_EMPTY,
        OCC_PART,
        OCC_FULL
    } occ_e;

    function automatic logic is_x0(input logic [RW-1:0] rd);
        return rd == '0;
    endfunction

endpackage

// File: rtl/riscv_wb_sched_if.sv
// riscv_wb_sched_if: writeback scheduler bus (ex/mem sources, rf write,
// forwarding query, status). master = pipeline side, slave = scheduler.
interface riscv_wb_sched_if
    import riscv_pkg::*;
#(
    parameter int XLEN = XLEN_D
);

    logic            ex_valid;
    logic [RW-1:0]   ex_rd;
    logic [XLEN-1:0] ex_data;
    logic            mem_valid;
    logic [RW-1:0]   mem_rd;
    logic [XLEN-1:0] mem_data;
    logic [RW-1:0]   q_rs;
    logic            wr_en;
    logic [RW-1:0]   wr_rd;
    logic [XLEN-1:0] wr_data;
    logic            bubble;
    logic            q_hit;
    logic [XLEN-1:0] q_data;
    logic            wr_on_zero;
    logic            overflow;

    modport master (
        output ex_valid, ex_rd, ex_data,
        output mem_valid, mem_rd, mem_data,
        output q_rs,
        input  wr_en, wr_rd, wr_data,
        input  bubble, q_hit, q_data,
        input  wr_on_zero, overflow
    );

    modport slave (
        input  ex_valid, ex_rd, ex_data,
        input  mem_valid, mem_rd, mem_data,
        input  q_rs,
        output wr_en, wr_rd, wr_data,
        output bubble, q_hit, q_data,
        output wr_on_zero, overflow
    );

endinterface

// File: rtl/riscv_wb_fifo.sv
// riscv_wb_fifo: circular queue of deferred ALU writes (rd + data).
// Ports: push/pop, head out, count, and age-ordered entry read-out.
module riscv_wb_fifo
    import riscv_pkg::*;
#(
    parameter int  XLEN  = XLEN_D,
    parameter int  DEPTH = DEPTH_D,
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic            pop,
    input  logic [RW-1:0]   push_rd,
    input  logic [XLEN-1:0] push_data,
    output logic [RW-1:0]   head_rd,
    output logic [XLEN-1:0] head_data,
    output logic [CW-1:0]   count,
    output logic            ent_vld  [DEPTH],
    output logic [RW-1:0]   ent_rd   [DEPTH],
    output logic [XLEN-1:0] ent_data [DEPTH]
);

    logic [RW-1:0]   rd_mem   [DEPTH];
    logic [XLEN-1:0] data_mem [DEPTH];
    logic [PW-1:0]   head_q, tail_q;
    logic [CW-1:0]   count_q;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Slot holding the i-th oldest entry.
    function automatic logic [PW-1:0] age_idx(
        input logic [PW-1:0] h,
        input int            i
    );
        int k;
        k = int'(h) + i;
        if (k >= DEPTH) k = k - DEPTH;
        return PW'(k);
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) tail_q <= inc(tail_q);
            if (pop)  head_q <= inc(head_q);
            unique case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Payload needs no reset: count gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            rd_mem[tail_q]   <= push_rd;
            data_mem[tail_q] <= push_data;
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_vld[i]  = CW'(i) < count_q;
            ent_rd[i]   = rd_mem[age_idx(head_q, i)];
            ent_data[i] = data_mem[age_idx(head_q, i)];
        end
    end

    assign head_rd   = rd_mem[head_q];
    assign head_data = data_mem[head_q];
    assign count     = count_q;

endmodule

// File: rtl/riscv_wb_sched.sv
// riscv_wb_sched: arbitrates mem, queued ALU and new ALU writes onto one
// rf write port (mem > queue > ex), queues losers, forwards queue contents.
module riscv_wb_sched
    import riscv_pkg::*;
#(
    parameter int XLEN  = XLEN_D,
    parameter int DEPTH = DEPTH_D
) (
    input logic             clk,
    input logic             rst,
    riscv_wb_sched_if.slave bus
);

    localparam int CW = $clog2(DEPTH + 1);

    logic            push, pop, drop;
    logic            sel_vld;
    logic [RW-1:0]   sel_rd;
    logic [XLEN-1:0] sel_data;
    logic [RW-1:0]   head_rd;
    logic [XLEN-1:0] head_data;
    logic [CW-1:0]   count;
    logic            ent_vld  [DEPTH];
    logic [RW-1:0]   ent_rd   [DEPTH];
    logic [XLEN-1:0] ent_data [DEPTH];
    occ_e            state_q, state_d;
    logic            is_empty, is_full;
    logic            wr_en_q, wr_on_zero_q, ovf_q;
    logic [RW-1:0]   wr_rd_q;
    logic [XLEN-1:0] wr_data_q;
    logic            q_hit;
    logic [XLEN-1:0] q_data;

    riscv_wb_fifo #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .push_rd   (bus.ex_rd),
        .push_data (bus.ex_data),
        .head_rd   (head_rd),
        .head_data (head_data),
        .count     (count),
        .ent_vld   (ent_vld),
        .ent_rd    (ent_rd),
        .ent_data  (ent_data)
    );

    assign is_empty = (state_q == OCC_EMPTY);
    assign is_full  = (state_q == OCC_FULL);

    // A new ex only goes straight out when nothing older is pending.
    always_comb begin
        sel_vld  = 1'b0;
        sel_rd   = '0;
        sel_data = '0;
        pop      = 1'b0;
        push     = 1'b0;
        drop     = 1'b0;
        if (bus.mem_valid) begin
            sel_vld  = 1'b1;
            sel_rd   = bus.mem_rd;
            sel_data = bus.mem_data;
        end else if (!is_empty) begin
            sel_vld  = 1'b1;
            sel_rd   = head_rd;
            sel_data = head_data;
            pop      = 1'b1;
        end else if (bus.ex_valid) begin
            sel_vld  = 1'b1;
            sel_rd   = bus.ex_rd;
            sel_data = bus.ex_data;
        end
        if (bus.ex_valid && (bus.mem_valid || !is_empty)) begin
            if (!is_full || pop) push = 1'b1;
            else                 drop = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            OCC_EMPTY: begin
                if (push)
                    state_d = (DEPTH == 1) ? OCC_FULL : OCC_PART;
            end
            OCC_PART: begin
                if (push && !pop && count == CW'(DEPTH - 1))
                    state_d = OCC_FULL;
                else if (pop && !push && count == CW'(1))
                    state_d = OCC_EMPTY;
            end
            OCC_FULL: begin
                if (pop && !push)
                    state_d = (DEPTH == 1) ? OCC_EMPTY : OCC_PART;
            end
            default: state_d = OCC_EMPTY;
        endcase
    end

    // wr_rd/wr_data only move on a real write so idle cycles stay quiet.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= OCC_EMPTY;
            wr_en_q      <= 1'b0;
            wr_rd_q      <= '0;
            wr_data_q    <= '0;
            wr_on_zero_q <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_en_q      <= sel_vld && !is_x0(sel_rd);
            wr_on_zero_q <= sel_vld && is_x0(sel_rd);
            if (sel_vld && !is_x0(sel_rd)) begin
                wr_rd_q   <= sel_rd;
                wr_data_q <= sel_data;
            end
            if (drop) ovf_q <= 1'b1;
        end
    end

    // Entries are scanned oldest first, so the last match is the youngest.
    always_comb begin
        q_hit  = 1'b0;
        q_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_vld[i] && ent_rd[i] == bus.q_rs
                && !is_x0(bus.q_rs)) begin
                q_hit  = 1'b1;
                q_data = ent_data[i];
            end
        end
    end

    assign bus.wr_en      = wr_en_q;
    assign bus.wr_rd      = wr_rd_q;
    assign bus.wr_data    = wr_data_q;
    assign bus.bubble     = is_full;
    assign bus.q_hit      = q_hit;
    assign bus.q_data     = q_data;
    assign bus.wr_on_zero = wr_on_zero_q;
    assign bus.overflow   = ovf_q;

endmodule
